// File: rtl/alu_mul_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_mul_seq_pkg
// Shared definitions for the sequential multiplier and the pipeline control
// unit: FSM state encoding, ALU op codes and the shift-and-add iteration count.
// ----------------------------------------------------------------------------
package alu_mul_seq_pkg;

    // Number of shift-and-add iterations for 32-bit operands.
    localparam int ITER_COUNT = 32;

    // ALU op codes understood by alu_mul_seq_alu.
    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_ADD = 4'b0000;
    localparam alu_op_t ALU_SUB = 4'b0100;
    localparam alu_op_t ALU_XOR = 4'b0010;

    // Multiplier sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEG_A  = 3'd1,
        S_NEG_B  = 3'd2,
        S_ITER   = 3'd3,
        S_FIX_LO = 3'd4,
        S_FIX_HI = 3'd5,
        S_FIX_HC = 3'd6,
        S_DONE   = 3'd7
    } mul_state_e;

endpackage : alu_mul_seq_pkg

// File: rtl/alu_mul_seq_alu.sv
// ----------------------------------------------------------------------------
// alu_mul_seq_alu
// Purely combinational 32-bit ALU shared by the multiplier sequencer.
// Ports:
//   op_i  [3:0]  operation select (ALU_ADD / ALU_SUB / ALU_XOR)
//   a_i   [31:0] first operand
//   b_i   [31:0] second operand
//   y_o   [31:0] result (a+b, a-b or a^b; zero for unknown op codes)
// ----------------------------------------------------------------------------
module alu_mul_seq_alu
    import alu_mul_seq_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    always_comb begin
        y_o = 32'h0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            default: y_o = 32'h0;
        endcase
    end

endmodule : alu_mul_seq_alu

// File: rtl/alu_mul_seq.sv
// ----------------------------------------------------------------------------
// alu_mul_seq
// Sequential 32x32 -> 64-bit multiplier (signed or unsigned) built on a single
// shared ALU, one ALU operation per cycle. Signed operands are converted to
// magnitudes, multiplied by shift-and-add, and the 64-bit product is negated
// at the end when the operand signs differ.
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high reset (priority over start)
//   start      multiply request, sampled only while busy=0
//   is_signed  operand signedness, sampled with start
//   a, b       multiplicand / multiplier, sampled with start
//   busy       high in every state except IDLE
//   done       one-cycle pulse, hi/lo valid in that cycle
//   hi, lo     upper / lower product word; hold the last result while idle
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0.
// start is ignored (never queued) while busy=1, including the DONE cycle, so
// the earliest back-to-back acceptance is the edge after done. done rises
// exactly 38 edges after acceptance, for every operand value and sign.
// ----------------------------------------------------------------------------
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] ITER_LAST = 5'(ITER_COUNT - 1);

    mul_state_e  state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sgn_q;
    logic        neg_q;     // product must be negated at the end
    logic        lz_q;      // low word was zero before negation -> carry into hi
    logic [31:0] mcand_q;   // multiplicand magnitude
    logic [31:0] hi_q;
    logic [31:0] lo_q;      // multiplier magnitude, shifted out as product grows
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    // Shared ALU operand selection, driven purely by the current state.
    alu_op_t     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = 32'h0;
        alu_b  = 32'h0;
        case (state_q)
            S_NEG_A: begin
                if (sgn_q && a_q[31]) begin
                    alu_op = ALU_SUB;
                    alu_a  = 32'h0;
                    alu_b  = a_q;
                end else begin
                    alu_op = ALU_ADD;
                    alu_a  = a_q;
                    alu_b  = 32'h0;
                end
            end
            S_NEG_B: begin
                if (sgn_q && b_q[31]) begin
                    alu_op = ALU_SUB;
                    alu_a  = 32'h0;
                    alu_b  = b_q;
                end else begin
                    alu_op = ALU_ADD;
                    alu_a  = b_q;
                    alu_b  = 32'h0;
                end
            end
            S_ITER: begin
                alu_op = ALU_ADD;
                alu_a  = hi_q;
                alu_b  = lo_q[0] ? mcand_q : 32'h0;
            end
            S_FIX_LO: begin
                alu_op = ALU_SUB;
                alu_a  = 32'h0;
                alu_b  = lo_q;
            end
            S_FIX_HI: begin
                alu_op = ALU_XOR;
                alu_a  = hi_q;
                alu_b  = 32'hFFFF_FFFF;
            end
            S_FIX_HC: begin
                alu_op = ALU_ADD;
                alu_a  = hi_q;
                alu_b  = {31'h0, lz_q};
            end
            default: begin
                alu_op = ALU_ADD;
                alu_a  = 32'h0;
                alu_b  = 32'h0;
            end
        endcase
    end

    alu_mul_seq_alu u_alu (
        .op_i (alu_op),
        .a_i  (alu_a),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    // A 32-bit add overflowed exactly when the sum wrapped below an operand.
    logic iter_carry_d;
    assign iter_carry_d = (alu_y < hi_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            lz_q    <= 1'b0;
            mcand_q <= 32'h0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sgn_q   <= is_signed;
                        neg_q   <= is_signed & (a[31] ^ b[31]);
                        lz_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_NEG_A;
                    end
                end
                S_NEG_A: begin
                    mcand_q <= alu_y;
                    state_q <= S_NEG_B;
                end
                S_NEG_B: begin
                    lo_q    <= alu_y;
                    hi_q    <= 32'h0;
                    cnt_q   <= 5'd0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    // {carry, sum, lo} >> 1 into {hi, lo}
                    hi_q  <= {iter_carry_d, alu_y[31:1]};
                    lo_q  <= {alu_y[0], lo_q[31:1]};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == ITER_LAST) begin
                        state_q <= S_FIX_LO;
                    end
                end
                S_FIX_LO: begin
                    // Two's complement of {hi,lo}: lo = -lo, hi = ~hi + (lo==0)
                    if (neg_q) begin
                        lo_q <= alu_y;
                        lz_q <= (lo_q == 32'h0);
                    end
                    state_q <= S_FIX_HI;
                end
                S_FIX_HI: begin
                    if (neg_q) begin
                        hi_q <= alu_y;
                    end
                    state_q <= S_FIX_HC;
                end
                S_FIX_HC: begin
                    if (neg_q) begin
                        hi_q <= alu_y;
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : alu_mul_seq

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: a reference product model fills an
// expected queue on every accepted request; a monitor pops and compares on done.
module tb_alu_mul_seq;

    localparam int W          = 64;
    localparam int LATENCY    = 38;
    localparam int WAIT_BOUND = 400;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int cyc = 0;   // number of rising edges seen so far

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    alu_mul_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           acc_q[$];   // edge number at which each request is accepted

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endfunction

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = sgn ? {{32{x[31]}}, x} : {32'h0, x};
        ey = sgn ? {{32{y[31]}}, y} : {32'h0, y};
        return ex * ey;
    endfunction

    // Monitor: sampled on the falling edge; done seen here was set by the
    // preceding rising edge and is sampled by the next one (cyc + 1).
    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                int          t;
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                check("product", {hi, lo}, e);
                check("latency", 64'(cyc + 1 - t), 64'(LATENCY));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (busy && n < WAIT_BOUND) begin
            @(negedge clock);
            n++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        wait_idle();
        a         = x;
        b         = y;
        is_signed = sgn;
        start     = 1'b1;
        exp_q.push_back(model(x, y, sgn));
        acc_q.push_back(cyc + 1);
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < WAIT_BOUND) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_low;
        int t0;

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // directed products
        run_op(32'd3, 32'd5, 1'b0);
        drain();
        repeat (5) @(negedge clock);
        check("hold_result", {hi, lo}, 64'h0000_0000_0000_000F);
        check("idle_busy", 64'(busy), 64'd0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFE, 32'd3,         1'b1);
        run_op(32'h8000_0000, 32'd1,         1'b1);
        run_op(32'h0000_0000, 32'hFFFF_FFFB, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(32'd7,         32'hFFFF_FFFF, 1'b1);
        drain();
        check("hold_last", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF9);

        // start pulsed mid-operation is ignored
        run_op(32'd3, 32'd5, 1'b0);          // accepted at edge T, now after edge T
        repeat (9) @(negedge clock);         // now between T+9 and T+10
        a = 32'd9; b = 32'd11; is_signed = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();
        repeat (45) @(negedge clock);        // any phantom second op would show here
        check("ignored_start", {hi, lo}, 64'd15);

        // reset during ITER
        run_op(32'd3, 32'd5, 1'b0);
        repeat (11) @(negedge clock);        // between T+11 and T+12
        reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        run_op(32'd6, 32'hFFFF_FFF9, 1'b1);
        drain();

        // start held high: acceptances every 39 edges, one idle cycle between
        wait_idle();
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; is_signed = 1'b1; start = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(model(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
            acc_q.push_back(t0 + k * (LATENCY + 1));
        end
        busy_low = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (!busy) busy_low++;
        end
        start = 1'b0;
        check("held_busy_gaps", 64'(busy_low), 64'd2);
        drain();

        // random operands
        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();

        repeat (45) @(negedge clock);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_alu_mul_seq

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only while busy=0.
REQ-005 is_signed  input  1  selects signed (1) or unsigned (0) operands; sampled with start.
REQ-006 a  input  32  multiplicand; sampled with start.
REQ-007 b  input  32  multiplier; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse marking valid hi/lo.
REQ-010 hi  output  32  upper product word.
REQ-011 lo  output  32  lower product word.

Function
REQ-012 The block SHALL compute the 64-bit product {hi,lo} = a*b by shift-and-add, with all 32-bit arithmetic through one internal alu instance, one ALU operation per cycle.
REQ-013 ALU op codes SHALL be: ADD 4'b0000, SUB 4'b0100, XOR 4'b0010.
REQ-014 States SHALL be: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, FIX_HC, DONE.
REQ-015 IDLE: if start=1 at edge T, latch a, b, is_signed; record neg = is_signed & (a[31]^b[31]); go to NEG_A; start while busy=1 SHALL be ignored, not queued.
REQ-016 NEG_A (T+1): mcand = (is_signed & a[31]) ? 0-a : a+0 via ALU.
REQ-017 NEG_B (T+2): lo = (is_signed & b[31]) ? 0-b : b+0 via ALU; hi = 0; iteration counter = 0.
REQ-018 ITER (T+3..T+34, exactly 32 cycles): sum = lo[0] ? hi+mcand : hi+0 via ALU; carry = (sum < hi, unsigned); then {carry,sum,lo} shifted right 1 into {hi,lo}; counter wraps 31->0 and exits to FIX_LO.
REQ-019 FIX_LO (T+35): if neg, lo = 0-lo via SUB and record lz = (old lo == 0); else unchanged.
REQ-020 FIX_HI (T+36): if neg, hi = hi XOR 32'hFFFFFFFF.
REQ-021 FIX_HC (T+37): if neg, hi = hi + (lz ? 1 : 0) via ADD.
REQ-022 DONE (T+38): done=1, busy=1, hi/lo final; next state IDLE.
REQ-023 Latency SHALL be fixed at 38 cycles from accepted start to done, independent of operand values and sign.
REQ-024 hi/lo SHALL hold the last result in IDLE until the next accepted start; intermediate values are visible during busy and SHALL NOT be relied on.
REQ-025 Signed 32'h80000000 SHALL be handled by its unsigned magnitude 2^31 (0-x wraps to itself).
REQ-026 start asserted in the DONE cycle SHALL be ignored; earliest back-to-back start is sampled one cycle after done.

Reset
REQ-027 reset=1 at any edge, including mid-operation, SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0, mcand=0, neg=0, lz=0 on that edge; reset SHALL take priority over start.

Structure
REQ-028 State encodings, ALU op code constants and ITER_COUNT=32 SHALL live in a shared package used by this block and the pipeline control unit.
REQ-029 One sub-module SHALL be used: the existing alu, instantiated once; carry detection, shifting and muxing stay in alu_mul_seq.

Verification
REQ-030 Unsigned 3*5, start at T -> done at T+38, hi=0, lo=32'h0000000F.
REQ-031 Unsigned FFFFFFFF*FFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-032 Signed -2*3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; signed 80000000*1 -> hi=FFFFFFFF, lo=80000000; signed 0*FFFFFFFB -> hi=0, lo=0.
REQ-033 start pulsed at T+10 with different operands during a busy 3*5 op -> ignored, result still 15 at T+38, no second done.
REQ-034 reset asserted at T+12 (ITER) -> next cycle busy=0, done=0, hi=lo=0; fresh start then completes normally in 38 cycles.
REQ-035 start held high continuously -> done pulses every 39 cycles, busy low exactly one cycle between operations.
